xcel_axi_read_adapter: RTL and testbench
========================================

// Module: xcel_axi_read_adapter
// PURPOSE
//  Sits downstream of xcel_naive_memif: converts its simplified read request / read data channel
//  into AXI4 master AR and R channels. Splits requests longer than 256 beats into several
//  AXI bursts. Forwards R beats to the requester and flags protocol and response errors.
// PARAMETERS
//  AXI_AWIDTH   32   address width (araddr, xcel_read_addr)
//  AXI_DWIDTH   32   data width (rdata, xcel_read_data)
//  AXI_IDWIDTH  4    ID width; arid is driven to 0
// PORTS
//  clk                      in   1            clock
//  rst_n                    in   1            asynchronous active-low reset
//  xcel_read_request_valid  in   1            request valid
//  xcel_read_request_ready  out  1            request accepted when valid&ready
//  xcel_read_addr           in   AXI_AWIDTH   start byte address
//  xcel_read_len            in   32           total beats minus 1
//  xcel_read_size           in   3            AXI size encoding (bytes = 1<<size)
//  xcel_read_burst          in   2            AXI burst type (FIXED=0, INCR=1)
//  xcel_read_data           out  AXI_DWIDTH   beat data
//  xcel_read_data_valid     out  1            beat valid
//  xcel_read_data_ready     in   1            requester can take the beat
//  m_axi_arid/araddr/arlen/arsize/arburst  out  IDW/AW/8/3/2  AR payload
//  m_axi_arvalid / m_axi_arready           out/in  1          AR handshake
//  m_axi_rid/rdata/rresp/rlast             in  IDW/DW/2/1     R payload
//  m_axi_rvalid / m_axi_rready             in/out  1          R handshake
//  rd_busy                  out  1            transaction in flight (not IDLE)
//  rd_error                 out  1            sticky: rresp!=OKAY or rlast mismatch
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE; arvalid=0, rready=0, xcel_read_data_valid=0,
//   xcel_read_request_ready=0 while rst_n=0, rd_busy=0, rd_error=0; beat counters cleared.
//  States: IDLE -> AR -> R -> (AR | IDLE).
//   IDLE: request_ready=1. On fire, latch addr, remaining = len+1 (33-bit), size, burst; -> AR.
//   AR:   arvalid=1; araddr=cur_addr; arlen=min(remaining,256)-1; arsize/arburst from latch.
//         AR payload stable while arvalid=1 and arready=0. On fire -> R; beat_cnt=0.
//   R:    rready = xcel_read_data_ready; xcel_read_data=rdata, xcel_read_data_valid=rvalid
//         (combinational pass-through, zero added latency, no buffering).
//         Each R fire: beat_cnt++, remaining--. On the last beat of the burst
//         (beat_cnt==arlen): if remaining after decrement is 0 -> IDLE, else -> AR with
//         cur_addr += (arlen+1)<<size for INCR, unchanged for FIXED.
//  Only one AXI burst outstanding; no new request accepted until back in IDLE.
//  Requester guarantees INCR bursts do not cross a 4 KB boundary.
//  rd_error set (sticky until reset) if rresp!=2'b00 on any fire, rlast=1 before the final
//   beat, or rlast=0 on the final beat. The beat count, not rlast, ends the burst.
//  rd_busy = (state != IDLE).
//  Width: remaining is 33 bits, so len=32'hFFFF_FFFF does not overflow. cur_addr wraps mod 2^AW.
//  Reset mid-transaction drops all state immediately. Any in-flight AXI beats after reset are
//   the system's responsibility (the adapter and the interconnect share one reset).
// TESTING
//  1. len=0, size=0, INCR, addr=0x1003 -> one AR: araddr=0x1003, arlen=0; one beat forwarded;
//     ends in IDLE, rd_error=0.
//  2. len=299, size=2, INCR, addr=0x0 -> AR#1 arlen=255 @0x0, AR#2 arlen=43 @0x400;
//     300 beats forwarded in order.
//  3. FIXED burst, len=299 -> both ARs use araddr=addr.
//  4. Randomly stall arready and xcel_read_data_ready -> AR payload stable while stalled;
//     no beat lost or duplicated; rready tracks xcel_read_data_ready.
//  5. rresp=2'b10 on beat 2, or rlast early -> rd_error=1 and stays 1; the transfer still
//     completes by beat count.
//  6. Assert rst_n=0 in the middle of an R burst -> all outputs reach reset values without a
//     clock edge; a new request after reset completes normally.

Source files
------------

// File: rtl/xcel_axi_read_adapter_if.sv
// Accelerator read request/data channel plus the AXI4 AR and R channels.
// master: the adapter side. slave: the requester and interconnect side.
interface xcel_axi_read_adapter_if #(
  parameter int unsigned AXI_AWIDTH  = 32,
  parameter int unsigned AXI_DWIDTH  = 32,
  parameter int unsigned AXI_IDWIDTH = 4
);
  logic                   xcel_read_request_valid;
  logic                   xcel_read_request_ready;
  logic [AXI_AWIDTH-1:0]  xcel_read_addr;
  logic [31:0]            xcel_read_len;
  logic [2:0]             xcel_read_size;
  logic [1:0]             xcel_read_burst;
  logic [AXI_DWIDTH-1:0]  xcel_read_data;
  logic                   xcel_read_data_valid;
  logic                   xcel_read_data_ready;

  logic [AXI_IDWIDTH-1:0] m_axi_arid;
  logic [AXI_AWIDTH-1:0]  m_axi_araddr;
  logic [7:0]             m_axi_arlen;
  logic [2:0]             m_axi_arsize;
  logic [1:0]             m_axi_arburst;
  logic                   m_axi_arvalid;
  logic                   m_axi_arready;

  logic [AXI_IDWIDTH-1:0] m_axi_rid;
  logic [AXI_DWIDTH-1:0]  m_axi_rdata;
  logic [1:0]             m_axi_rresp;
  logic                   m_axi_rlast;
  logic                   m_axi_rvalid;
  logic                   m_axi_rready;

  modport master (
    input  xcel_read_request_valid, xcel_read_addr, xcel_read_len, xcel_read_size,
           xcel_read_burst, xcel_read_data_ready,
    output xcel_read_request_ready, xcel_read_data, xcel_read_data_valid,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output xcel_read_request_valid, xcel_read_addr, xcel_read_len, xcel_read_size,
           xcel_read_burst, xcel_read_data_ready,
    input  xcel_read_request_ready, xcel_read_data, xcel_read_data_valid,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/xcel_axi_read_adapter.sv
// Converts a simplified read request into one or more AXI4 read bursts (max 256 beats each)
// and passes R beats straight through to the requester, flagging response/rlast errors.
module xcel_axi_read_adapter #(
  parameter int unsigned AXI_AWIDTH  = 32,
  parameter int unsigned AXI_DWIDTH  = 32,
  parameter int unsigned AXI_IDWIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  xcel_axi_read_adapter_if.master bus,
  output logic                    rd_busy,
  output logic                    rd_error
);
  localparam int unsigned REM_W  = 33;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned STEP_W = 16;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
  logic [REM_W-1:0]        remaining_q, remaining_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [LEN_W-1:0]        burst_len_q, burst_len_d;
  logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    error_q, error_d;

  logic                    req_fire_c;
  logic                    ar_fire_c;
  logic                    r_fire_c;
  logic                    last_beat_c;
  logic [LEN_W-1:0]        ar_len_c;
  logic [REM_W-1:0]        rem_dec_c;
  logic [STEP_W-1:0]       step_c;
  logic                    unused_rid;

  // Only a single ID is ever issued, so the returned ID carries no information.
  assign unused_rid = ^bus.m_axi_rid;

  // Handshake decode and burst arithmetic shared by the FSM and datapath.
  always_comb begin
    req_fire_c  = (state_q == ST_IDLE) && bus.xcel_read_request_valid;
    ar_fire_c   = (state_q == ST_AR) && bus.m_axi_arready;
    r_fire_c    = (state_q == ST_R) && bus.m_axi_rvalid && bus.xcel_read_data_ready;
    last_beat_c = (beat_cnt_q == burst_len_q);
    rem_dec_c   = remaining_q - REM_W'(1);
    ar_len_c    = (remaining_q >= REM_W'(256)) ? '1 : LEN_W'(remaining_q - REM_W'(1));
    step_c      = STEP_W'(STEP_W'(burst_len_q) + STEP_W'(1)) << size_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the beat count, not rlast, closes a burst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_fire_c) state_d = ST_AR;
      ST_AR:   if (ar_fire_c) state_d = ST_R;
      ST_R: begin
        if (r_fire_c && last_beat_c) begin
          state_d = (rem_dec_c == '0) ? ST_IDLE : ST_AR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; R channel is a zero-latency pass-through to the requester.
  always_comb begin
    bus.xcel_read_request_ready = 1'b0;
    bus.xcel_read_data_valid    = 1'b0;
    bus.xcel_read_data          = bus.m_axi_rdata;
    bus.m_axi_arvalid           = 1'b0;
    bus.m_axi_rready            = 1'b0;
    bus.m_axi_arid              = '0;
    bus.m_axi_araddr            = addr_q;
    bus.m_axi_arlen             = ar_len_c;
    bus.m_axi_arsize            = size_q;
    bus.m_axi_arburst           = burst_q;
    rd_busy                     = 1'b0;
    rd_error                    = error_q;
    unique case (state_q)
      ST_IDLE: bus.xcel_read_request_ready = rst_n;
      ST_AR: begin
        bus.m_axi_arvalid = 1'b1;
        rd_busy           = 1'b1;
      end
      ST_R: begin
        bus.m_axi_rready         = bus.xcel_read_data_ready;
        bus.xcel_read_data_valid = bus.m_axi_rvalid;
        rd_busy                  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      error_q     <= error_d;
    end
  end

  // Datapath next values: latch request, snapshot burst length at AR, count beats, track errors.
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    size_d      = size_q;
    burst_d     = burst_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    error_d     = error_q;
    if (req_fire_c) begin
      addr_d      = bus.xcel_read_addr;
      remaining_d = REM_W'(bus.xcel_read_len) + REM_W'(1);
      size_d      = bus.xcel_read_size;
      burst_d     = bus.xcel_read_burst;
    end
    if (ar_fire_c) begin
      burst_len_d = ar_len_c;
      beat_cnt_d  = '0;
    end
    if (r_fire_c) begin
      beat_cnt_d  = beat_cnt_q + LEN_W'(1);
      remaining_d = rem_dec_c;
      if (last_beat_c && (burst_q == BURST_INCR)) begin
        addr_d = addr_q + AXI_AWIDTH'(step_c);
      end
      if ((bus.m_axi_rresp != RESP_OKAY) || (bus.m_axi_rlast != last_beat_c)) begin
        error_d = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_xcel_axi_read_adapter.sv
// Scoreboard bench: expected ARs and beats are queued when a request is issued and
// checked as the AXI slave model and requester sink observe handshakes.
module tb_xcel_axi_read_adapter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned IDW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_busy;
  logic rd_error;

  xcel_axi_read_adapter_if #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .AXI_IDWIDTH(IDW)) bus ();

  xcel_axi_read_adapter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .AXI_IDWIDTH(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rd_busy  (rd_busy),
    .rd_error (rd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    int unsigned   tag;
    int unsigned   base;
  } ar_exp_t;

  ar_exp_t       ar_q[$];
  logic [DW-1:0] beat_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            stall_ar = 1'b0;
  bit            stall_r  = 1'b0;
  int            err_resp_at   = -1;
  int            early_last_at = -1;
  int unsigned   cur_tag = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_word(input int unsigned tag, input int unsigned idx);
    return DW'({tag[11:0], idx[19:0]});
  endfunction

  // AXI slave model: random arready, random rvalid gaps, optional error injection.
  initial begin : axi_slave
    bit            in_burst = 1'b0;
    bit            holding  = 1'b0;
    bit            ar_held  = 1'b0;
    ar_exp_t       cur;
    int unsigned   bidx = 0;
    int unsigned   nbeats = 0;
    int unsigned   g;
    logic [AW+14:0] held_ar;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rid     = '0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_burst = 1'b0;
        holding  = 1'b0;
        ar_held  = 1'b0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        continue;
      end
      if (!in_burst) begin
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_arready = stall_ar ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (ar_held && bus.m_axi_arvalid) begin
          check_eq("ar_stable", {bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst},
                   held_ar);
        end
        ar_held = 1'b0;
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          if (ar_q.size() == 0) begin
            check_eq("ar_unexpected", 1, 0);
          end else begin
            cur = ar_q.pop_front();
            check_eq("ar_addr", bus.m_axi_araddr, cur.addr);
            check_eq("ar_len", bus.m_axi_arlen, cur.len);
            check_eq("ar_size_burst", {bus.m_axi_arsize, bus.m_axi_arburst}, {cur.size, cur.burst});
            check_eq("ar_id", bus.m_axi_arid, 0);
            in_burst = 1'b1;
            holding  = 1'b0;
            bidx     = 0;
            nbeats   = int'(cur.len) + 1;
          end
        end else if (bus.m_axi_arvalid) begin
          ar_held = 1'b1;
          held_ar = {bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst};
        end
      end else begin
        bus.m_axi_arready = 1'b0;
        if (!holding) begin
          g = cur.base + bidx;
          bus.m_axi_rvalid = stall_r ? ($urandom_range(0, 3) != 0) : 1'b1;
          bus.m_axi_rdata  = beat_word(cur.tag, g);
          bus.m_axi_rid    = IDW'(cur.tag);
          bus.m_axi_rresp  = (int'(g) == err_resp_at) ? 2'b10 : 2'b00;
          bus.m_axi_rlast  = (bidx == nbeats - 1) || (int'(g) == early_last_at);
        end
        #1;
        check_eq("rready_track", bus.m_axi_rready, bus.xcel_read_data_ready);
        check_eq("dvalid_pass", bus.xcel_read_data_valid, bus.m_axi_rvalid);
        check_eq("arvalid_in_r", bus.m_axi_arvalid, 0);
        if (bus.m_axi_rvalid) check_eq("rdata_pass", bus.xcel_read_data, bus.m_axi_rdata);
        holding = bus.m_axi_rvalid && !bus.m_axi_rready;
        if (bus.m_axi_rvalid && bus.m_axi_rready) begin
          bidx++;
          if (bidx == nbeats) in_burst = 1'b0;
        end
      end
    end
  end

  // Requester data sink: random back-pressure, checks beat order against the scoreboard.
  initial begin : data_sink
    logic [DW-1:0] e;
    bus.xcel_read_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.xcel_read_data_ready = stall_r ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rst_n && bus.xcel_read_data_valid && bus.xcel_read_data_ready) begin
        if (beat_q.size() == 0) begin
          check_eq("beat_unexpected", 1, 0);
        end else begin
          e = beat_q.pop_front();
          check_eq("beat_data", bus.xcel_read_data, e);
        end
      end
    end
  end

  task automatic issue_req(input logic [AW-1:0] addr, input logic [31:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int unsigned max_beats);
    longint unsigned rem;
    logic [AW-1:0]   a;
    int unsigned     base;
    int unsigned     l;
    int unsigned     n;
    cur_tag++;
    rem  = longint'(len) + 1;
    a    = addr;
    base = 0;
    while (rem > 0 && base < max_beats) begin
      l = (rem > 256) ? 255 : int'(rem - 1);
      ar_q.push_back('{a, 8'(l), size, burst, cur_tag, base});
      if (burst == 2'b01) a = a + AW'((l + 1) << size);
      base += l + 1;
      rem  -= longint'(l + 1);
    end
    for (int unsigned i = 0; i < base; i++) beat_q.push_back(beat_word(cur_tag, i));
    @(negedge clk);
    bus.xcel_read_request_valid = 1'b1;
    bus.xcel_read_addr          = addr;
    bus.xcel_read_len           = len;
    bus.xcel_read_size          = size;
    bus.xcel_read_burst         = burst;
    #1;
    n = 0;
    while (!bus.xcel_read_request_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("req_ready", bus.xcel_read_request_ready, 1);
    @(negedge clk);
    bus.xcel_read_request_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((rd_busy || beat_q.size() != 0) && n < 20000);
    check_eq({tag, "_busy"}, rd_busy, 0);
    check_eq({tag, "_beats_left"}, beat_q.size(), 0);
    check_eq({tag, "_ar_left"}, ar_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_arvalid"}, bus.m_axi_arvalid, 0);
    check_eq({tag, "_rready"}, bus.m_axi_rready, 0);
    check_eq({tag, "_dvalid"}, bus.xcel_read_data_valid, 0);
    check_eq({tag, "_req_ready"}, bus.xcel_read_request_ready, 0);
    check_eq({tag, "_busy"}, rd_busy, 0);
    check_eq({tag, "_error"}, rd_error, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_pulse");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : main
    int n;
    bus.xcel_read_request_valid = 1'b0;
    bus.xcel_read_addr          = '0;
    bus.xcel_read_len           = '0;
    bus.xcel_read_size          = '0;
    bus.xcel_read_burst         = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("idle_req_ready", bus.xcel_read_request_ready, 1);

    // single byte beat
    issue_req(32'h0000_1003, 32'd0, 3'd0, 2'b01, 4096);
    wait_done("t1");
    check_eq("t1_error", rd_error, 0);

    // split into 256 + 44 beats
    issue_req(32'h0000_0000, 32'd299, 3'd2, 2'b01, 4096);
    wait_done("t2");
    check_eq("t2_error", rd_error, 0);

    // FIXED keeps the address
    issue_req(32'h0000_2000, 32'd299, 3'd2, 2'b00, 4096);
    wait_done("t3");
    check_eq("t3_error", rd_error, 0);

    // random stalls on both sides
    stall_ar = 1'b1;
    stall_r  = 1'b1;
    issue_req(32'h0000_3000, 32'd599, 3'd2, 2'b01, 4096);
    wait_done("t4a");
    issue_req(32'h0000_5010, 32'd5, 3'd3, 2'b01, 4096);
    wait_done("t4b");
    check_eq("t4_error", rd_error, 0);

    // SLVERR on beat 2 is sticky and the transfer completes
    err_resp_at = 2;
    issue_req(32'h0000_4000, 32'd9, 3'd2, 2'b01, 4096);
    wait_done("t5a");
    check_eq("t5a_error", rd_error, 1);
    err_resp_at = -1;
    issue_req(32'h0000_4100, 32'd3, 3'd2, 2'b01, 4096);
    wait_done("t5a_clean");
    check_eq("t5a_sticky", rd_error, 1);
    pulse_reset();

    // early rlast flagged; burst still ends by count
    early_last_at = 3;
    issue_req(32'h0000_4200, 32'd9, 3'd2, 2'b01, 4096);
    wait_done("t5b");
    check_eq("t5b_error", rd_error, 1);
    early_last_at = -1;
    pulse_reset();

    // reset in the middle of a maximum-length FIXED transfer
    issue_req(32'h0000_6000, 32'hFFFF_FFFF, 3'd2, 2'b00, 600);
    n = 0;
    while (beat_q.size() > 450 && n < 5000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("t6_progress", (beat_q.size() <= 450), 1);
    check_eq("t6_busy_before", rd_busy, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    beat_q.delete();
    ar_q.delete();
    stall_ar = 1'b0;
    stall_r  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue_req(32'h0000_7000, 32'd20, 3'd2, 2'b01, 4096);
    wait_done("t6_after");
    check_eq("t6_after_error", rd_error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
